// File: rtl/wb_regfile_pkg.sv
// Shared widths, bus types and enable constants for the write-back register file.
// Combinational only; carries no handshake.
package wb_regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_RPORTS = 4;

  typedef logic [REG_DATA_W-1:0] RegBus;
  typedef logic [REG_ADDR_W-1:0] RegAddrBus;

  localparam RegBus     ZeroWord     = '0;
  localparam RegAddrBus NOPRegAddr   = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      RstEnable    = 1'b1;

endpackage

// File: rtl/wb_regfile_if.sv
// Commit stream plus four read ports of the write-back register file.
// Latency 0 on reads; no handshake, so the slave never back-pressures.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              we1;
  logic              we2;
  logic [ADDR_W-1:0] waddr1;
  logic [ADDR_W-1:0] waddr2;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic              whilo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              llbit_we;
  logic              llbit_i;
  logic              llbit_clr;

  logic [NUM_RPORTS-1:0] re;
  logic [ADDR_W-1:0]     raddr [NUM_RPORTS];
  logic [DATA_W-1:0]     rdata [NUM_RPORTS];
  logic [DATA_W-1:0]     hi_o;
  logic [DATA_W-1:0]     lo_o;
  logic                  llbit_o;

  modport master (
    output we1, we2, waddr1, waddr2, wdata1, wdata2,
    output whilo, hi_i, lo_i, llbit_we, llbit_i, llbit_clr,
    output re, raddr,
    input  rdata, hi_o, lo_o, llbit_o
  );

  modport slave (
    input  we1, we2, waddr1, waddr2, wdata1, wdata2,
    input  whilo, hi_i, lo_i, llbit_we, llbit_i, llbit_clr,
    input  re, raddr,
    output rdata, hi_o, lo_o, llbit_o
  );

endinterface

// File: rtl/wb_regfile_gpr_read_port.sv
// One GPR read port: r0/re/reset masking and write-through bypass from both commit slots.
// Purely combinational, latency 0; no backpressure.
module wb_regfile_gpr_read_port
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [DATA_W-1:0] arr_dat,
  output logic [DATA_W-1:0] rdata
);

  // Slot2 is younger, so its bypass beats slot1 exactly as it wins in the array.
  always_comb begin
    rdata = '0;
    if (rst != RstEnable && re == ReadEnable && raddr != '0) begin
      if (we2 == WriteEnable && waddr2 == raddr) begin
        rdata = wdata2;
      end else if (we1 == WriteEnable && waddr1 == raddr) begin
        rdata = wdata1;
      end else begin
        rdata = arr_dat;
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 32 GPRs (r0 = 0), HI/LO and LLbit, four bypassed read ports.
// Writes land on the next edge but are visible in the same cycle; never back-pressures.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic           clk,
  input logic           rst,
  wb_regfile_if.slave   bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              llbit_q;

  // Slot2 is written last, so on an address clash its value is the one kept.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.we1 == WriteEnable && bus.waddr1 != '0) begin
        mem[bus.waddr1] <= bus.wdata1;
      end
      if (bus.we2 == WriteEnable && bus.waddr2 != '0) begin
        mem[bus.waddr2] <= bus.wdata2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q    <= '0;
      lo_q    <= '0;
      llbit_q <= 1'b0;
    end else begin
      if (bus.whilo == WriteEnable) begin
        hi_q <= bus.hi_i;
        lo_q <= bus.lo_i;
      end
      if (bus.llbit_clr) begin
        llbit_q <= 1'b0;
      end else if (bus.llbit_we == WriteEnable) begin
        llbit_q <= bus.llbit_i;
      end
    end
  end

  always_comb begin
    bus.hi_o    = '0;
    bus.lo_o    = '0;
    bus.llbit_o = 1'b0;
    if (rst != RstEnable) begin
      bus.hi_o    = (bus.whilo == WriteEnable) ? bus.hi_i : hi_q;
      bus.lo_o    = (bus.whilo == WriteEnable) ? bus.lo_i : lo_q;
      bus.llbit_o = bus.llbit_clr ? 1'b0 :
                    (bus.llbit_we == WriteEnable) ? bus.llbit_i : llbit_q;
    end
  end

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
    wb_regfile_gpr_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .rst     (rst),
      .re      (bus.re[k]),
      .raddr   (bus.raddr[k]),
      .we1     (bus.we1),
      .waddr1  (bus.waddr1),
      .wdata1  (bus.wdata1),
      .we2     (bus.we2),
      .waddr2  (bus.waddr2),
      .wdata2  (bus.wdata2),
      .arr_dat (mem[bus.raddr[k]]),
      .rdata   (bus.rdata[k])
    );
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus a randomized commit/read stream against an array model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mdl_mem [32];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;
  logic        mdl_ll;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // Expected outputs from the architectural rules and the current inputs.
  function automatic logic [31:0] exp_rd(input int k);
    if (rst) return ZeroWord;
    if (!bus.re[k] || bus.raddr[k] == NOPRegAddr) return ZeroWord;
    if (bus.we2 && bus.waddr2 == bus.raddr[k]) return bus.wdata2;
    if (bus.we1 && bus.waddr1 == bus.raddr[k]) return bus.wdata1;
    return mdl_mem[bus.raddr[k]];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return ZeroWord;
    return bus.whilo ? bus.hi_i : mdl_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return ZeroWord;
    return bus.whilo ? bus.lo_i : mdl_lo;
  endfunction

  function automatic logic exp_ll();
    if (rst || bus.llbit_clr) return 1'b0;
    return bus.llbit_we ? bus.llbit_i : mdl_ll;
  endfunction

  task automatic clear_inputs();
    bus.we1 = WriteDisable;  bus.we2 = WriteDisable;
    bus.waddr1 = '0; bus.waddr2 = '0;
    bus.wdata1 = '0; bus.wdata2 = '0;
    bus.whilo = WriteDisable; bus.hi_i = '0; bus.lo_i = '0;
    bus.llbit_we = WriteDisable; bus.llbit_i = 1'b0; bus.llbit_clr = 1'b0;
    bus.re = '0;
    for (int k = 0; k < 4; k++) bus.raddr[k] = '0;
  endtask

  task automatic rand_inputs();
    bus.we1    = 1'($urandom_range(0, 1));
    bus.we2    = 1'($urandom_range(0, 1));
    bus.waddr1 = 5'($urandom_range(0, 7));
    bus.waddr2 = 5'($urandom_range(0, 7));
    bus.wdata1 = $urandom;
    bus.wdata2 = $urandom;
    bus.whilo  = 1'($urandom_range(0, 1));
    bus.hi_i   = $urandom;
    bus.lo_i   = $urandom;
    bus.llbit_we  = 1'($urandom_range(0, 1));
    bus.llbit_i   = 1'($urandom_range(0, 1));
    bus.llbit_clr = ($urandom_range(0, 3) == 0);
    bus.re = 4'($urandom);
    for (int k = 0; k < 4; k++) bus.raddr[k] = 5'($urandom_range(0, 7));
  endtask

  // Advance one clock edge and apply the same commit to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
      mdl_hi = '0; mdl_lo = '0; mdl_ll = 1'b0;
    end else begin
      if (bus.we1 && bus.waddr1 != 0) mdl_mem[bus.waddr1] = bus.wdata1;
      if (bus.we2 && bus.waddr2 != 0) mdl_mem[bus.waddr2] = bus.wdata2;
      if (bus.whilo) begin mdl_hi = bus.hi_i; mdl_lo = bus.lo_i; end
      if (bus.llbit_clr) mdl_ll = 1'b0;
      else if (bus.llbit_we) mdl_ll = bus.llbit_i;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rand_inputs();
      tick();
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rand_inputs();
      bus.re = 4'hF; bus.we1 = 1'b1; bus.we2 = 1'b1; bus.whilo = 1'b1;
      bus.llbit_we = 1'b1; bus.llbit_i = 1'b1; bus.llbit_clr = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (bus.rdata[k] !== 32'h0) begin
          errors++;
          $display("FAIL reset_rdata%0d: got %h expected 00000000", k, bus.rdata[k]);
        end
      end
      checks++;
      if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.llbit_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hilo_ll: got hi=%h lo=%h ll=%b expected 0/0/0", bus.hi_o, bus.lo_o, bus.llbit_o);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    bus.re = 4'hF;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 4; k++) bus.raddr[k] = 5'(g * 4 + k);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (bus.rdata[k] !== 32'h0) begin
          errors++;
          $display("FAIL post_reset_r%0d: got %h expected 00000000", g * 4 + k, bus.rdata[k]);
        end
      end
      tick();
    end
    checks++;
    if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.llbit_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_hilo_ll: got hi=%h lo=%h ll=%b expected 0/0/0", bus.hi_o, bus.lo_o, bus.llbit_o);
    end
  endtask

  task automatic test_bypass();
    clear_inputs();
    bus.we1 = 1'b1; bus.waddr1 = 5'd5; bus.wdata1 = 32'h1234;
    bus.re[0] = 1'b1; bus.raddr[0] = 5'd5;
    @(negedge clk);
    checks++;
    if (bus.rdata[0] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected 00001234", bus.rdata[0]);
    end
    tick();
    bus.we1 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rdata[0] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_from_array: got %h expected 00001234", bus.rdata[0]);
    end
    tick();
  endtask

  task automatic test_dual_write();
    clear_inputs();
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'hAAAA;
    bus.we2 = 1'b1; bus.waddr2 = 5'd9; bus.wdata2 = 32'hBBBB;
    bus.re = 4'b0110; bus.raddr[1] = 5'd9; bus.raddr[2] = 5'd9;
    @(negedge clk);
    checks++;
    if (bus.rdata[1] !== 32'hBBBB || bus.rdata[2] !== 32'hBBBB) begin
      errors++;
      $display("FAIL dual_same_cycle: got %h/%h expected 0000bbbb", bus.rdata[1], bus.rdata[2]);
    end
    tick();
    bus.we1 = 1'b0; bus.we2 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rdata[1] !== 32'hBBBB) begin
      errors++;
      $display("FAIL dual_stored: got %h expected 0000bbbb", bus.rdata[1]);
    end
    tick();
  endtask

  task automatic test_r0();
    clear_inputs();
    bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFF_FFFF;
    bus.we2 = 1'b1; bus.waddr2 = 5'd0; bus.wdata2 = 32'hDEAD_BEEF;
    bus.re = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (bus.rdata[k] !== 32'h0) begin
          errors++;
          $display("FAIL r0_port%0d_cycle%0d: got %h expected 00000000", k, c, bus.rdata[k]);
        end
      end
      tick();
      bus.we1 = 1'b0; bus.we2 = 1'b0;
    end
  endtask

  task automatic test_hilo();
    clear_inputs();
    bus.whilo = 1'b1; bus.hi_i = 32'h1; bus.lo_i = 32'h2;
    @(negedge clk);
    checks++;
    if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2) begin
      errors++;
      $display("FAIL hilo_same_cycle: got %h/%h expected 00000001/00000002", bus.hi_o, bus.lo_o);
    end
    tick();
    bus.whilo = 1'b0; bus.hi_i = 32'h5555_0000; bus.lo_i = 32'h0000_7777;
    @(negedge clk);
    checks++;
    if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2) begin
      errors++;
      $display("FAIL hilo_held: got %h/%h expected 00000001/00000002", bus.hi_o, bus.lo_o);
    end
    tick();
  endtask

  task automatic test_llbit();
    clear_inputs();
    bus.llbit_we = 1'b1; bus.llbit_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.llbit_o !== 1'b1) begin
      errors++;
      $display("FAIL llbit_set: got %b expected 1", bus.llbit_o);
    end
    tick();
    bus.llbit_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.llbit_o !== 1'b1) begin
      errors++;
      $display("FAIL llbit_held: got %b expected 1", bus.llbit_o);
    end
    bus.llbit_we = 1'b1; bus.llbit_i = 1'b1; bus.llbit_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.llbit_o !== 1'b0) begin
      errors++;
      $display("FAIL llbit_clr_same_cycle: got %b expected 0", bus.llbit_o);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.llbit_o !== 1'b0) begin
      errors++;
      $display("FAIL llbit_clr_stored: got %b expected 0", bus.llbit_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'hA0A0_0001;
    tick();
    bus.wdata1 = 32'hB0B0_0002;
    bus.we2 = 1'b1; bus.waddr2 = 5'd8; bus.wdata2 = 32'hC0C0_0003;
    bus.re = 4'b1001; bus.raddr[0] = 5'd7; bus.raddr[3] = 5'd8;
    @(negedge clk);
    checks++;
    if (bus.rdata[0] !== 32'hB0B0_0002 || bus.rdata[3] !== 32'hC0C0_0003) begin
      errors++;
      $display("FAIL b2b_bypass: got %h/%h expected b0b00002/c0c00003", bus.rdata[0], bus.rdata[3]);
    end
    tick();
    bus.we1 = 1'b0; bus.we2 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rdata[0] !== 32'hB0B0_0002 || bus.rdata[3] !== 32'hC0C0_0003) begin
      errors++;
      $display("FAIL b2b_stored: got %h/%h expected b0b00002/c0c00003", bus.rdata[0], bus.rdata[3]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      rand_inputs();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = exp_rd(k);
        checks++;
        if (bus.rdata[k] !== e) begin
          errors++;
          $display("FAIL rand_rdata%0d cyc%0d: got %h expected %h", k, c, bus.rdata[k], e);
        end
      end
      checks++;
      if (bus.hi_o !== exp_hi() || bus.lo_o !== exp_lo()) begin
        errors++;
        $display("FAIL rand_hilo cyc%0d: got %h/%h expected %h/%h", c, bus.hi_o, bus.lo_o, exp_hi(), exp_lo());
      end
      checks++;
      if (bus.llbit_o !== exp_ll()) begin
        errors++;
        $display("FAIL rand_llbit cyc%0d: got %b expected %b", c, bus.llbit_o, exp_ll());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    tick();
    tick();
    test_reset();
    test_bypass();
    test_dual_write();
    test_r0();
    test_hilo();
    test_llbit();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
